// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pkg: shared types and constants for the IF-stage PC generator.
//   fetch_state_e : fetch sequencer states (BOOT, RUN, WAIT_IC)
//   PC_W          : program counter width
//   RESET_PC_DEF  : default first fetch address
//   NOP_INST_DEF  : default bubble instruction (addi x0,x0,0)
//   align_pc()    : clears the two low address bits
package fetch_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0]     NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    WAIT_IC = 2'd2
  } fetch_state_e;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: I-cache read port between the fetch unit and the cache.
//   ic_req   : read request (fetch -> cache)
//   ic_addr  : read address (fetch -> cache)
//   ic_stall : cache busy; ic_rdata valid when ic_req=1 and ic_stall=0
//   ic_rdata : fetched instruction word (cache -> fetch)
// Modports: master = fetch unit, slave = I-cache.
interface fetch_pc_unit_if;
  import fetch_pkg::*;

  logic            ic_req;
  logic [PC_W-1:0] ic_addr;
  logic            ic_stall;
  logic [31:0]     ic_rdata;

  modport master (output ic_req, output ic_addr, input  ic_stall, input  ic_rdata);
  modport slave  (input  ic_req, input  ic_addr, output ic_stall, output ic_rdata);

endinterface

// File: rtl/fetch_pc_unit_id_reg.sv
// fetch_id_reg: pipeline register carrying one instruction, its PC and its
// predicted-taken bit into the next stage. Reused for ID/EX.
//   clk, rst   : clock, synchronous active-high reset (clears to NOP)
//   load       : capture in_inst/in_pc/in_pred and mark valid
//   kill       : drop the held instruction (valid=0, inst=NOP); beats load
//   (neither)  : hold
//   valid/inst/pc/pred : registered outputs
module fetch_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            kill,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic            in_pred,
  output logic            valid,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] pc,
  output logic            pred
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
      pc    <= '0;
      pred  <= 1'b0;
    end else if (kill) begin
      // Invalid slots always present NOP downstream; pc/pred are don't-care.
      valid <= 1'b0;
      inst  <= NOP_INST;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= in_inst;
      pc    <= in_pc;
      pred  <= in_pred;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF-stage PC generator and fetch sequencer.
//   clk, rst        : clock, synchronous active-high reset
//   pc_1            : current fetch PC to the BTB
//   btb_branch_pc/btb_flush/btb_taken : BTB next PC, redirect, prediction
//   ic              : I-cache read port (fetch_pc_unit_if.master)
//   id_ready        : decode can accept
//   id_valid/id_inst/id_pc/id_pred_taken : ID register outputs
// Optional (macro FETCH_PERF_CNT_EN): perf_flush_cnt, perf_stall_cnt,
// saturating event counters cleared by rst.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0]     NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   pc_1,
  input  logic [PC_W-1:0]   btb_branch_pc,
  input  logic              btb_flush,
  input  logic              btb_taken,
  fetch_pc_unit_if.master   ic,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [31:0]       id_inst,
  output logic [PC_W-1:0]   id_pc,
  output logic              id_pred_taken
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  fetch_state_e    state, state_nxt;
  logic [PC_W-1:0] pc_r, redir_pc, pc_nxt, br_al;
  logic            pc_load, redir_load, id_load, id_kill;

  assign br_al      = align_pc(btb_branch_pc);
  assign pc_1       = pc_r;
  assign ic.ic_addr = pc_r;

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (btb_flush && ic.ic_stall) state_nxt = WAIT_IC;
      WAIT_IC: if (!ic.ic_stall) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    ic.ic_req  = 1'b0;
    pc_load    = 1'b0;
    pc_nxt     = br_al;
    redir_load = 1'b0;
    id_load    = 1'b0;
    id_kill    = 1'b0;
    case (state)
      RUN: begin
        ic.ic_req = 1'b1;
        if (btb_flush) begin
          // Redirect kills the wrong-path ID slot even if decode is stalled.
          id_kill = 1'b1;
          if (ic.ic_stall) redir_load = 1'b1;
          else             pc_load    = 1'b1;
        end else if (ic.ic_stall) begin
          id_kill = id_ready;
        end else if (id_ready) begin
          id_load = 1'b1;
          pc_load = 1'b1;
        end
      end
      WAIT_IC: begin
        // Address frozen until the in-flight access completes; its data is dropped.
        ic.ic_req  = 1'b1;
        redir_load = btb_flush;
        if (!ic.ic_stall) begin
          pc_load = 1'b1;
          pc_nxt  = btb_flush ? br_al : redir_pc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= RESET_PC;
      redir_pc <= '0;
    end else begin
      if (pc_load)    pc_r     <= pc_nxt;
      if (redir_load) redir_pc <= br_al;
    end
  end

  fetch_id_reg #(.NOP_INST(NOP_INST)) u_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (id_load),
    .kill    (id_kill),
    .in_inst (ic.ic_rdata),
    .in_pc   (pc_r),
    .in_pred (btb_taken),
    .valid   (id_valid),
    .inst    (id_inst),
    .pc      (id_pc),
    .pred    (id_pred_taken)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (btb_flush && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (ic.ic_req && (ic.ic_stall || !id_ready) && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] btb_branch_pc = '0;
  logic        btb_flush = 1'b0;
  logic        btb_taken = 1'b0;
  logic        id_ready  = 1'b1;
  logic [31:0] pc_1, id_inst, id_pc;
  logic        id_valid, id_pred_taken;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_flush_cnt, perf_stall_cnt;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  fetch_pc_unit_if ic_if ();

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_1          (pc_1),
    .btb_branch_pc (btb_branch_pc),
    .btb_flush     (btb_flush),
    .btb_taken     (btb_taken),
    .ic            (ic_if),
    .id_ready      (id_ready),
    .id_valid      (id_valid),
    .id_inst       (id_inst),
    .id_pc         (id_pc),
    .id_pred_taken (id_pred_taken)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_flush_cnt(perf_flush_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    return 32'h1000_0000 ^ a;
  endfunction

  // Cache model: word at an address is a tag of that address; garbage while busy.
  always_comb ic_if.ic_rdata = ic_if.ic_stall ? 32'hDEAD_BEEF : inst_at(ic_if.ic_addr);

  // Behavioural model of the fetch unit's architectural outputs.
  logic [31:0] m_pc = '0, m_redir = '0, m_inst = 32'h13, m_idpc = '0;
  logic        m_boot = 1'b1, m_wait = 1'b0, m_idv = 1'b0, m_pred = 1'b0;
  bit          started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 32'h0; m_redir <= '0; m_boot <= 1'b1; m_wait <= 1'b0;
      m_idv <= 1'b0; m_inst <= 32'h13; m_idpc <= '0; m_pred <= 1'b0;
      started <= 1'b1;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (m_wait) begin
      if (!ic_if.ic_stall) begin
        m_pc   <= btb_flush ? {btb_branch_pc[31:2], 2'b00} : m_redir;
        m_wait <= 1'b0;
      end else if (btb_flush) begin
        m_redir <= {btb_branch_pc[31:2], 2'b00};
      end
    end else if (btb_flush) begin
      m_idv <= 1'b0; m_inst <= 32'h13;
      if (ic_if.ic_stall) begin
        m_redir <= {btb_branch_pc[31:2], 2'b00};
        m_wait  <= 1'b1;
      end else begin
        m_pc <= {btb_branch_pc[31:2], 2'b00};
      end
    end else if (ic_if.ic_stall) begin
      if (id_ready) begin m_idv <= 1'b0; m_inst <= 32'h13; end
    end else if (id_ready) begin
      m_idv <= 1'b1; m_inst <= inst_at(m_pc); m_idpc <= m_pc; m_pred <= btb_taken;
      m_pc  <= {btb_branch_pc[31:2], 2'b00};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("pc_1",     pc_1,              m_pc);
      chk("ic_addr",  ic_if.ic_addr,     m_pc);
      chk("ic_req",   {31'd0, ic_if.ic_req}, {31'd0, !m_boot});
      chk("id_valid", {31'd0, id_valid}, {31'd0, m_idv});
      chk("id_inst",  id_inst,           m_inst);
      if (m_idv) begin
        chk("id_pc",   id_pc,                  m_idpc);
        chk("id_pred", {31'd0, id_pred_taken}, {31'd0, m_pred});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic stall, input logic flush, input logic ready,
                       input logic taken, input logic [31:0] br);
    ic_if.ic_stall = stall; btb_flush = flush; id_ready = ready;
    btb_taken = taken; btb_branch_pc = br;
    cyc();
  endtask

  // Mixed-pattern table: {stall, flush, ready, taken, pc offset}
  logic [3:0]  t_ctl [8] = '{4'b0010, 4'b0011, 4'b1010, 4'b0000,
                             4'b0110, 4'b1100, 4'b1110, 4'b0010};
  logic [31:0] t_off [8] = '{32'd4, 32'h20, 32'd4, 32'd4,
                             32'h1C6, 32'h80, 32'h13, 32'd4};

  initial begin
    ic_if.ic_stall = 1'b0;
    cyc();                                        // reset edge
    chk("rst pc_1",     pc_1, 32'h0);
    chk("rst ic_req",   {31'd0, ic_if.ic_req}, 32'd0);
    chk("rst id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst id_inst",  id_inst, 32'h0000_0013);
    chk("rst id_pc",    id_pc, 32'h0);
    rst = 1'b0;
    cyc();                                        // BOOT -> RUN
    chk("run ic_req",   {31'd0, ic_if.ic_req}, 32'd1);
    chk("run addr0",    ic_if.ic_addr, 32'h0);
    drive(0, 0, 1, 0, 32'h4);
    chk("seq addr4", ic_if.ic_addr, 32'h4);
    chk("seq idpc0", id_pc, 32'h0);
    chk("seq idv",   {31'd0, id_valid}, 32'd1);
    drive(0, 0, 1, 0, 32'h8);
    chk("seq addr8", ic_if.ic_addr, 32'h8);
    chk("seq idpc4", id_pc, 32'h4);
    drive(0, 0, 1, 1, 32'h40);                    // predicted taken at 8
    chk("taken addr",  ic_if.ic_addr, 32'h40);
    chk("taken idpc",  id_pc, 32'h8);
    chk("taken pred",  {31'd0, id_pred_taken}, 32'd1);
    chk("taken inst",  id_inst, 32'h1000_0008);
    drive(0, 1, 0, 0, 32'h100);                   // flush while decode stalled
    chk("flush idv",  {31'd0, id_valid}, 32'd0);
    chk("flush addr", ic_if.ic_addr, 32'h100);
    drive(0, 0, 1, 0, 32'h104);
    chk("post flush idpc", id_pc, 32'h100);
    drive(1, 0, 1, 0, 32'h108);                   // stall 1: bubble
    chk("stall1 addr", ic_if.ic_addr, 32'h104);
    chk("stall1 idv",  {31'd0, id_valid}, 32'd0);
    drive(1, 1, 1, 0, 32'h202);                   // stall 2 + flush (unaligned)
    chk("stall2 addr", ic_if.ic_addr, 32'h104);
    drive(1, 0, 1, 0, 32'h9990);                  // stall 3
    chk("stall3 addr", ic_if.ic_addr, 32'h104);
    drive(0, 0, 1, 0, 32'h9990);                  // stall ends, data dropped
    chk("redir addr", ic_if.ic_addr, 32'h200);
    chk("redir idv",  {31'd0, id_valid}, 32'd0);
    chk("redir inst", id_inst, 32'h0000_0013);
    drive(0, 0, 1, 0, 32'h204);
    drive(0, 0, 0, 0, 32'h208);                   // decode hazard x2
    drive(0, 0, 0, 0, 32'h208);
    chk("hold idpc", id_pc, 32'h200);
    chk("hold inst", id_inst, 32'h1000_0200);
    chk("hold addr", ic_if.ic_addr, 32'h204);
    drive(0, 0, 1, 0, 32'h208);
    chk("resume idpc", id_pc, 32'h204);
    chk("resume addr", ic_if.ic_addr, 32'h208);
    drive(0, 1, 1, 0, 32'hFFFF_FFFC);
    drive(0, 0, 1, 0, m_pc + 32'd4);              // wraps to 0
    chk("wrap addr", ic_if.ic_addr, 32'h0);
    chk("wrap idpc", id_pc, 32'hFFFF_FFFC);
    for (int unsigned r = 0; r < 3; r++)
      for (int unsigned i = 0; i < 8; i++)
        drive(t_ctl[i][3], t_ctl[i][2], t_ctl[i][1], t_ctl[i][0], m_pc + t_off[i]);
    drive(0, 0, 1, 0, m_pc + 32'd4);
    drive(1, 1, 1, 0, 32'h300);                   // enter WAIT_IC
    rst = 1'b1;
    cyc();
    chk("wrst ic_req",  {31'd0, ic_if.ic_req}, 32'd0);
    chk("wrst pc_1",    pc_1, 32'h0);
    chk("wrst id_inst", id_inst, 32'h0000_0013);
    chk("wrst id_valid",{31'd0, id_valid}, 32'd0);
    rst = 1'b0;
    drive(0, 0, 1, 0, 32'h4);
    drive(0, 0, 1, 0, 32'h4);
    chk("after rst addr", ic_if.ic_addr, 32'h4);
    drive(0, 0, 1, 0, 32'h8);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
IF-stage PC generator and fetch sequencer for the RISC-V pipeline.
- Holds the architectural fetch PC and presents it to the BTB as the stage-1 PC.
- Takes the BTB's next-PC, flush and taken outputs, drives the I-cache request, and passes each fetched instruction to decode with its PC and predicted-taken bit.
- Decode carries the predicted-taken bit down to stage 3, where it returns to the BTB as prev_taken_3.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned).
- NOP_INST, 32'h0000_0013, instruction word driven to decode when id_valid=0.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- pc_1, output, 32, current fetch PC to BTB instructionPC_1.
- btb_branch_pc, input, 32, BTB next PC (predicted target, PC+4, or stage-3 correction).
- btb_flush, input, 1, BTB misprediction redirect.
- btb_taken, input, 1, BTB predicted taken for pc_1.
- ic_req, output, 1, I-cache read request.
- ic_addr, output, 32, I-cache read address.
- ic_stall, input, 1, I-cache busy; ic_rdata is valid in a cycle with ic_req=1 and ic_stall=0.
- ic_rdata, input, 32, fetched instruction.
- id_ready, input, 1, decode can accept (low = hazard stall).
- id_valid, output, 1, ID register holds a live instruction.
- id_inst, output, 32, instruction to decode.
- id_pc, output, 32, PC of id_inst.
- id_pred_taken, output, 1, BTB prediction captured with id_inst.

Behaviour:
Reset:
- rst sampled high at a posedge gives pc_r=RESET_PC, state=BOOT, redir_pc=0.
- Outputs after reset: id_valid=0, id_inst=NOP_INST, id_pc=0, id_pred_taken=0, ic_req=0.
- rst has priority over every other input, including mid-stall or mid-redirect.

Combinational outputs:
- pc_1 = ic_addr = pc_r.
- ic_req = 1 in RUN and WAIT_IC, 0 in BOOT.

States:
- BOOT: one cycle, no request, then RUN.
- RUN, accept condition ic_stall=0, id_ready=1, btb_flush=0:
  - id_valid<=1, id_inst<=ic_rdata, id_pc<=pc_r, id_pred_taken<=btb_taken.
  - pc_r<={btb_branch_pc[31:2],2'b00}.
  - Throughput is one instruction per cycle; latency from ic_rdata to ID register is 1 clock.
- RUN, ic_stall=1, btb_flush=0:
  - pc_r holds.
  - If id_ready=1: id_valid<=0 (bubble). If id_ready=0: the ID register holds.
- RUN, ic_stall=0, id_ready=0, btb_flush=0:
  - pc_r and the ID register hold; the request repeats at the same address.
- RUN, btb_flush=1, ic_stall=0:
  - pc_r<={btb_branch_pc[31:2],2'b00}; id_valid<=0 (kills the wrong-path ID instruction) regardless of id_ready; ic_rdata is discarded.
- RUN, btb_flush=1, ic_stall=1:
  - redir_pc<=aligned btb_branch_pc; id_valid<=0; go to WAIT_IC.
- WAIT_IC:
  - ic_addr stays at the old pc_r, because an in-flight cache transaction must not change address.
  - A further btb_flush overwrites redir_pc.
  - When ic_stall=0: discard ic_rdata, pc_r<=redir_pc (or the new btb_branch_pc if btb_flush is high that same cycle), go to RUN. id_valid stays 0.

Invariants:
- Bits [1:0] of pc_r are always 0.
- PC arithmetic is 32-bit and wraps modulo 2^32; 32'hFFFF_FFFC+4 = 0.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_flush_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_flush_cnt increments on every cycle with btb_flush=1.
  - perf_stall_cnt increments on every cycle with ic_req=1 and (ic_stall=1 or id_ready=0).
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: no counter ports and no counter logic.

Decomposition:
- Package fetch_pkg holds:
  - the state enum {BOOT, RUN, WAIT_IC}, 2 bits;
  - the constants RESET_PC_DEF and NOP_INST_DEF;
  - the PC width 32.
- Sub-module fetch_id_reg: the ID pipeline register with hold/kill/load controls and reset to NOP. It is reused by the ID/EX stage.

Test Plan:
- Reset then 4 cycles, btb_taken=0, btb_branch_pc=pc_1+4, no stalls -> ic_addr 0,4,8 on successive RUN cycles; id_pc 0,4 with id_valid=1 starting 1 cycle after the first request.
- BTB predicts taken at PC 8 (btb_taken=1, btb_branch_pc=0x40) -> next ic_addr=0x40; id_pc=8 with id_pred_taken=1.
- btb_flush=1, btb_branch_pc=0x100, id_ready=0 -> id_valid=0 next cycle; ic_addr=0x100.
- ic_stall high 3 cycles, btb_flush with 0x200 in cycle 2 -> ic_addr holds the old PC through the stall; after the stall, ic_rdata is dropped and ic_addr=0x200, id_valid=0.
- id_ready=0 for 2 cycles -> id_inst/id_pc/id_valid unchanged and ic_addr constant; resumes with no lost or duplicated PC.
- rst asserted during WAIT_IC -> next cycle state=BOOT, ic_req=0, pc_1=RESET_PC, id_inst=0x00000013.
